num_stream_driver: RTL and testbench
====================================

NUM_STREAM_DRIVER -- requirements
Module: num_stream_driver

Interface
REQ-001 Parameter MAX_OUT, default 8, SHALL set the maximum number of issued numbers awaiting a result (legal 1..15).
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 start  input  1  SHALL be a one-cycle request to begin a sweep; sampled only in IDLE or DONE.
REQ-005 lo  input  32  SHALL be the first number of the sweep, captured when start is accepted.
REQ-006 hi  input  32  SHALL be the last number of the sweep (inclusive), captured when start is accepted.
REQ-007 num_o  output  32  SHALL be the number presented to the checker chain.
REQ-008 num_valid  output  1  SHALL be high when num_o holds a valid number.
REQ-009 num_ready  input  1  SHALL be the checker's acceptance; a transfer occurs when num_valid and num_ready are both high.
REQ-010 res_valid  input  1  SHALL mark one returned checker result; results return in issue order.
REQ-011 res_flag  input  1  SHALL be the checker verdict (the chain's final rout); 1 = pass.
REQ-012 busy  output  1  SHALL be high in ISSUE and DRAIN.
REQ-013 done  output  1  SHALL be high in DONE and held until the next accepted start or rst.
REQ-014 pass_count  output  32  SHALL be the number of results with res_flag=1 in the current sweep.
REQ-015 total_count  output  32  SHALL be the number of results received in the current sweep.
REQ-016 err  output  1  SHALL be a sticky flag for a protocol violation (REQ-027).

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, ISSUE, DRAIN, DONE.
REQ-018 IDLE/DONE + start: if lo<=hi (unsigned), go to ISSUE with cur=lo, pass_count=0, total_count=0, outstanding=0; otherwise go to DONE with both counts 0.
REQ-019 In ISSUE, num_valid SHALL equal (outstanding < MAX_OUT), and num_o SHALL equal cur.
REQ-020 num_o and num_valid SHALL stay stable while num_valid=1 and num_ready=0.
REQ-021 On a transfer: outstanding+1; if cur==hi, go to DRAIN, else cur=cur+1. cur SHALL never wrap (hi=0xFFFFFFFF ends at 0xFFFFFFFF).
REQ-022 On res_valid with outstanding>0: outstanding-1, total_count+1, and pass_count+1 if res_flag=1.
REQ-023 A transfer and a result in the same cycle SHALL leave outstanding unchanged and apply both count updates.
REQ-024 In DRAIN, num_valid SHALL be 0; when outstanding reaches 0 (after that cycle's result), go to DONE.
REQ-025 Issue-to-done latency SHALL be the cycle after the last result is counted.
REQ-026 start SHALL be ignored in ISSUE and DRAIN.
REQ-027 res_valid with outstanding=0 SHALL be ignored for counting and SHALL set err; err clears only on rst or an accepted start.
REQ-028 Counts SHALL saturate at 0xFFFFFFFF.
REQ-029 num_o SHALL hold its last value when num_valid=0.

Reset
REQ-030 On rst: state=IDLE, num_o=0, num_valid=0, busy=0, done=0, pass_count=0, total_count=0, err=0, outstanding=0.
REQ-031 rst SHALL take priority over every other input; rst mid-sweep SHALL abandon the sweep, and results arriving afterwards SHALL set err.

Verification
REQ-032 lo=10, hi=13, num_ready=1, results returned 3 cycles after issue with flags 1,0,1,1 -> num_o 10..13 on consecutive cycles, done with pass_count=3, total_count=4.
REQ-033 lo=5, hi=4, start -> DONE the next cycle, counts 0, num_valid never asserted.
REQ-034 MAX_OUT=2, lo=0, hi=5, results withheld -> only 0 and 1 issued, num_valid low until a result returns.
REQ-035 num_ready=0 for 5 cycles while num_valid=1 -> num_o stable; one transfer when num_ready rises.
REQ-036 lo=hi=0xFFFFFFFF -> exactly one issue (0xFFFFFFFF), no wrap to 0, done after one result.
REQ-037 rst at cycle 2 of a sweep, then 1 stray res_valid -> all outputs at reset values, err=1, counts 0.

Source files
------------

// File: rtl/num_stream_driver.sv
// Issues an inclusive sweep of numbers lo..hi to a checker chain and
// tallies the in-order pass/fail results it returns.
module num_stream_driver #(
    parameter int unsigned MAX_OUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic [31:0] num_o,
    output logic        num_valid,
    input  logic        num_ready,
    input  logic        res_valid,
    input  logic        res_flag,
    output logic        busy,
    output logic        done,
    output logic [31:0] pass_count,
    output logic [31:0] total_count,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] cur;
    logic [31:0] cur_n;
    logic [31:0] hi_q;
    logic [31:0] hi_n;
    logic [31:0] pass_n;
    logic [31:0] total_n;
    logic [3:0]  outst;
    logic [3:0]  outst_n;
    logic        err_n;
    logic        xfer;
    logic        res;

    assign num_o     = cur;
    assign num_valid = (state == ISSUE) && (32'(outst) < MAX_OUT);
    assign busy      = (state == ISSUE) || (state == DRAIN);
    assign done      = (state == DONE);

    always_comb begin
        state_n = state;
        cur_n   = cur;
        hi_n    = hi_q;
        pass_n  = pass_count;
        total_n = total_count;
        err_n   = err;
        xfer    = num_valid && num_ready;
        res     = res_valid && (outst != 4'd0);

        // a result with nothing in flight is a protocol error
        if (res_valid && (outst == 4'd0)) begin
            err_n = 1'b1;
        end
        if (res) begin
            if (total_count != 32'hFFFF_FFFF) begin
                total_n = total_count + 32'd1;
            end
            if (res_flag && (pass_count != 32'hFFFF_FFFF)) begin
                pass_n = pass_count + 32'd1;
            end
        end
        outst_n = outst + {3'b000, xfer} - {3'b000, res};

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    err_n   = 1'b0;
                    pass_n  = 32'd0;
                    total_n = 32'd0;
                    outst_n = 4'd0;
                    hi_n    = hi;
                    if (lo <= hi) begin
                        cur_n   = lo;
                        state_n = ISSUE;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            ISSUE: begin
                if (xfer) begin
                    // stop on hi rather than increment, so cur never wraps
                    if (cur == hi_q) begin
                        state_n = DRAIN;
                    end else begin
                        cur_n = cur + 32'd1;
                    end
                end
            end
            DRAIN: begin
                if (outst_n == 4'd0) begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cur         <= 32'd0;
            hi_q        <= 32'd0;
            outst       <= 4'd0;
            pass_count  <= 32'd0;
            total_count <= 32'd0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            cur         <= cur_n;
            hi_q        <= hi_n;
            outst       <= outst_n;
            pass_count  <= pass_n;
            total_count <= total_n;
            err         <= err_n;
        end
    end

endmodule

// File: tb/tb_num_stream_driver.sv
// Directed bench for num_stream_driver: a cycle table for a basic sweep
// plus hand-written sequences for backpressure, limits and reset.
module tb_num_stream_driver;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        num_ready;
    logic        res_valid;
    logic        res_flag;

    logic [31:0] num_o;
    logic        num_valid;
    logic        busy;
    logic        done;
    logic [31:0] pass_count;
    logic [31:0] total_count;
    logic        err;

    logic [31:0] num_o2;
    logic        num_valid2;
    logic        busy2;
    logic        done2;
    logic [31:0] pass_count2;
    logic [31:0] total_count2;
    logic        err2;

    int n_chk;
    int n_fail;

    num_stream_driver #(.MAX_OUT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi),
        .num_o(num_o), .num_valid(num_valid), .num_ready(num_ready),
        .res_valid(res_valid), .res_flag(res_flag),
        .busy(busy), .done(done), .pass_count(pass_count),
        .total_count(total_count), .err(err)
    );

    num_stream_driver #(.MAX_OUT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi),
        .num_o(num_o2), .num_valid(num_valid2), .num_ready(num_ready),
        .res_valid(res_valid), .res_flag(res_flag),
        .busy(busy2), .done(done2), .pass_count(pass_count2),
        .total_count(total_count2), .err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        rdy;
        logic        rv;
        logic        rf;
        logic        ev;
        logic        eb;
        logic        ed;
        logic [31:0] en;
        logic [31:0] ep;
        logic [31:0] et;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [99:0] act,
                       input logic [99:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        start     = 1'b0;
        res_valid = 1'b0;
        res_flag  = 1'b0;
        num_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic vec_t mk(
        input logic s, input logic r, input logic v, input logic f,
        input logic ev, input logic eb, input logic ed,
        input logic [31:0] en, input logic [31:0] ep, input logic [31:0] et);
        vec_t x;
        x.start = s;  x.rdy = r;  x.rv = v;  x.rf = f;
        x.ev = ev;    x.eb = eb;  x.ed = ed;
        x.en = en;    x.ep = ep;  x.et = et;
        return x;
    endfunction

    initial begin
        n_chk  = 0;
        n_fail = 0;
        lo     = 32'd0;
        hi     = 32'd0;

        tbl[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,  32'd0, 32'd0);
        tbl[1] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd10, 32'd0, 32'd0);
        tbl[2] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd11, 32'd0, 32'd0);
        tbl[3] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd12, 32'd0, 32'd0);
        tbl[4] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd13, 32'd0, 32'd0);
        tbl[5] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd13, 32'd1, 32'd1);
        tbl[6] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd13, 32'd1, 32'd2);
        tbl[7] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd13, 32'd2, 32'd3);
        tbl[8] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd13, 32'd3, 32'd4);
        tbl[9] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd13, 32'd3, 32'd4);

        // reset state
        do_reset();
        #1;
        chk("reset", 100'({num_valid, busy, done, err, num_o,
                           pass_count, total_count}), 100'd0);

        // basic sweep 10..13
        lo = 32'd10;
        hi = 32'd13;
        for (int i = 0; i < 10; i++) begin
            start     = tbl[i].start;
            num_ready = tbl[i].rdy;
            res_valid = tbl[i].rv;
            res_flag  = tbl[i].rf;
            #1;
            chk($sformatf("sweep_row%0d", i),
                100'({num_valid, busy, done, num_o, pass_count, total_count}),
                100'({tbl[i].ev, tbl[i].eb, tbl[i].ed,
                      tbl[i].en, tbl[i].ep, tbl[i].et}));
            step();
        end

        // empty range lo > hi
        do_reset();
        lo    = 32'd5;
        hi    = 32'd4;
        start = 1'b1;
        #1;
        chk("inv_start_valid", 100'(num_valid), 100'd0);
        step();
        start = 1'b0;
        #1;
        chk("inv_done", 100'({done, busy, num_valid, pass_count, total_count}),
            100'({3'b100, 64'd0}));
        step();
        #1;
        chk("inv_hold", 100'({done, num_valid}), 100'({2'b10}));

        // outstanding limit with MAX_OUT=2
        do_reset();
        lo        = 32'd0;
        hi        = 32'd5;
        num_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        #1;
        chk("mo_issue0", 100'({num_valid2, num_o2}), 100'({1'b1, 32'd0}));
        step();
        #1;
        chk("mo_issue1", 100'({num_valid2, num_o2}), 100'({1'b1, 32'd1}));
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            chk($sformatf("mo_stall%0d", i), 100'({num_valid2, num_o2}),
                100'({1'b0, 32'd2}));
        end
        res_valid = 1'b1;
        res_flag  = 1'b1;
        #1;
        chk("mo_res_cycle", 100'(num_valid2), 100'd0);
        step();
        res_valid = 1'b0;
        #1;
        chk("mo_resume", 100'({num_valid2, num_o2, pass_count2, total_count2}),
            100'({1'b1, 32'd2, 32'd1, 32'd1}));

        // backpressure: num_o stable while not ready
        do_reset();
        lo    = 32'd100;
        hi    = 32'd101;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp_stall%0d", i), 100'({num_valid, num_o}),
                100'({1'b1, 32'd100}));
            step();
        end
        num_ready = 1'b1;
        #1;
        chk("bp_accept", 100'({num_valid, num_o}), 100'({1'b1, 32'd100}));
        step();
        num_ready = 1'b0;
        #1;
        chk("bp_next", 100'({num_valid, num_o}), 100'({1'b1, 32'd101}));
        step();
        #1;
        chk("bp_next_hold", 100'({num_valid, num_o}), 100'({1'b1, 32'd101}));

        // top of range: no wrap
        do_reset();
        lo        = 32'hFFFF_FFFF;
        hi        = 32'hFFFF_FFFF;
        num_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        #1;
        chk("max_issue", 100'({num_valid, num_o}), 100'({1'b1, 32'hFFFF_FFFF}));
        step();
        #1;
        chk("max_drain", 100'({num_valid, busy, num_o}),
            100'({2'b01, 32'hFFFF_FFFF}));
        res_valid = 1'b1;
        res_flag  = 1'b1;
        step();
        res_valid = 1'b0;
        #1;
        chk("max_done", 100'({done, num_valid, num_o, pass_count, total_count}),
            100'({2'b10, 32'hFFFF_FFFF, 32'd1, 32'd1}));

        // reset mid-sweep, then a stray result
        do_reset();
        lo        = 32'd0;
        hi        = 32'd9;
        num_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rst_mid", 100'({num_valid, busy, done, err, num_o,
                             pass_count, total_count}), 100'd0);
        res_valid = 1'b1;
        res_flag  = 1'b1;
        step();
        res_valid = 1'b0;
        #1;
        chk("rst_stray", 100'({num_valid, busy, done, err, num_o,
                               pass_count, total_count}),
            100'({4'b0001, 96'd0}));
        num_ready = 1'b0;
        lo        = 32'd1;
        hi        = 32'd1;
        start     = 1'b1;
        step();
        start = 1'b0;
        #1;
        chk("err_clear", 100'({err, busy, num_valid, num_o}),
            100'({3'b011, 32'd1}));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
